// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU result, load-return handshake and register-file write port.
// The upstream side uses master; the arbiter uses slave.
interface wb_arbiter_if #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_stall;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_stall, mem_ready,
        input  rf_write_enable, rf_write_addr, rf_write_data,
        input  fifo_count
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_stall, mem_ready,
        output rf_write_enable, rf_write_addr, rf_write_data,
        output fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take the register-file port first, buffered
// load returns drain behind them with r0 suppression, squash and anti-starvation.
module wb_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_W-1:0]     addr_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]     addr_d [FIFO_DEPTH];
    logic [DATA_W-1:0]     data_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] squash_q, squash_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ST_W-1:0]  starve_q, starve_d;
    logic             stall_q, stall_d;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic mem_ready;
    logic enq;
    logic deq;
    logic nonempty;
    logic alu_hit;

    assign mem_ready = count_q < CNT_W'(FIFO_DEPTH);
    assign nonempty  = count_q != '0;
    assign enq       = bus.mem_valid && mem_ready;
    assign deq       = !bus.alu_valid && nonempty;
    assign alu_hit   = bus.alu_valid && (bus.alu_addr != '0);

    always_comb begin
        addr_d    = addr_q;
        data_d    = data_q;
        squash_d  = squash_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        starve_d  = starve_q;
        stall_d   = 1'b0;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;

        if (bus.alu_valid) begin
            rf_we_d   = bus.alu_addr != '0;
            rf_addr_d = bus.alu_addr;
            rf_data_d = bus.alu_data;
        end else if (nonempty) begin
            rf_we_d   = !squash_q[rd_ptr_q] && (addr_q[rd_ptr_q] != '0);
            rf_addr_d = addr_q[rd_ptr_q];
            rf_data_d = data_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        end

        // Stale slots may get marked too; enqueue rewrites the bit anyway.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_hit && (addr_q[i] == bus.alu_addr)) begin
                squash_d[i] = 1'b1;
            end
        end

        if (enq) begin
            addr_d[wr_ptr_q]   = bus.mem_addr;
            data_d[wr_ptr_q]   = bus.mem_data;
            squash_d[wr_ptr_q] = alu_hit && (bus.mem_addr == bus.alu_addr);
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end

        if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (!enq && deq) begin
            count_d = count_q - CNT_W'(1);
        end

        // Non-empty without a dequeue means the ALU held the port.
        if (deq || !nonempty) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q + ST_W'(1);
            if (starve_d == ST_W'(STARVE_LIMIT)) begin
                stall_d  = 1'b1;
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            squash_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            squash_q  <= squash_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign bus.alu_stall       = stall_q;
    assign bus.mem_ready       = mem_ready;
    assign bus.rf_write_enable = rf_we_q;
    assign bus.rf_write_addr   = rf_addr_q;
    assign bus.rf_write_data   = rf_data_q;
    assign bus.fifo_count      = count_q;
endmodule
